bus_reg_bank: RTL

Parametrised, clock-domain-safe register bank behind the external processor bus. The bus strobes (`ws_n`, `rs_n`, `as`) are asynchronous to `clk`. The block synchronises them, detects their falling edges, and runs one single-cycle write or read per strobe through a small FSM. It generalises the fixed 8×32 bank: configurable width, depth and synchroniser length, plus a write-event pulse, a busy flag and a full control-register output (word 0).

---
 rtl/bus_reg_pkg.sv | 30 +++
 rtl/strobe_sync.sv | 47 ++++
 rtl/bus_reg_bank.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bus_reg_pkg.sv
// Shared definitions for the bus register bank: FSM state encoding,
// index-width helper and synchroniser reset constants.
package bus_reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Idle level of the active-low strobes and of the active-high chip select
    localparam logic STB_N_RST_VAL = 1'b1;
    localparam logic CS_RST_VAL    = 1'b0;

    // Number of index bits needed to address 'depth' words
    function automatic int idx_width(input int depth);
        int w;
        w = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < depth) begin
                w = i + 32'sd1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/strobe_sync.sv
// Multi-flop synchroniser for one asynchronous bus strobe, with an optional
// falling-edge detector fed from one extra flop behind the chain.
module strobe_sync #(
    parameter int   STAGES  = 3,
    parameter logic RST_VAL = 1'b1,
    parameter bit   EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic fall_out
);

    logic [STAGES-1:0] chain_r;

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_r <= {STAGES{RST_VAL}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain_r[STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic dly_r;

            // Delay the synced level by one cycle so a 1->0 step can be seen
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dly_r <= RST_VAL;
                end else begin
                    dly_r <= sync_out;
                end
            end

            assign fall_out = dly_r & ~sync_out;
        end else begin : g_no_edge
            assign fall_out = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/bus_reg_bank.sv
// Register bank behind the asynchronous processor bus. Strobes are
// synchronised, their falling edges start one single-cycle write or read.
// Optional feature: define BUS_REG_BANK_RANGE_CHECK_EN to reject accesses
// whose upper address bits are non-zero and flag them on range_err.
module bus_reg_bank
    import bus_reg_pkg::*;
#(
    parameter int              DATA_W      = 32,
    parameter int              DEPTH       = 8,
    parameter int              ADDR_W      = 24,
    parameter int              SYNC_STAGES = 3,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    localparam int             IDX_W       = idx_width(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W/8-1:0] be,
    input  logic                ws_n,
    input  logic                rs_n,
    input  logic                as,
    output logic [DATA_W-1:0]   data_out,
    output logic [DATA_W-1:0]   ctrl_q,
    output logic                wr_stb,
    output logic [IDX_W-1:0]    wr_idx,
    output logic                busy,
    output logic                range_err
);

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DATA_W-1:0] data_out_r;
    logic              wr_stb_r;
    logic [IDX_W-1:0]  wr_idx_r;
    logic              busy_r;
    state_t            state_r;
    state_t            state_nxt_s;

    logic ws_sync_s, ws_fall_s;
    logic rs_sync_s, rs_fall_s;
    logic as_sync_s, as_fall_unused_s;
    logic wr_start_s, rd_start_s;
    logic in_range_s;
    logic [IDX_W-1:0] idx_s;
    logic unused_addr_s;

    strobe_sync #(.STAGES(SYNC_STAGES), .RST_VAL(STB_N_RST_VAL), .EDGE_EN(1'b1)) u_ws_sync (
        .clk(clk), .rst(rst), .async_in(ws_n), .sync_out(ws_sync_s), .fall_out(ws_fall_s)
    );

    strobe_sync #(.STAGES(SYNC_STAGES), .RST_VAL(STB_N_RST_VAL), .EDGE_EN(1'b1)) u_rs_sync (
        .clk(clk), .rst(rst), .async_in(rs_n), .sync_out(rs_sync_s), .fall_out(rs_fall_s)
    );

    strobe_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CS_RST_VAL), .EDGE_EN(1'b0)) u_as_sync (
        .clk(clk), .rst(rst), .async_in(as), .sync_out(as_sync_s), .fall_out(as_fall_unused_s)
    );

    // Byte offset bits never select anything; upper bits only matter with range checking
    assign unused_addr_s = ^{address[ADDR_W-1:IDX_W+2], address[1:0]};
    assign idx_s         = address[IDX_W+1:2];
    assign wr_start_s    = ws_fall_s & as_sync_s;
    assign rd_start_s    = rs_fall_s & as_sync_s;

`ifdef BUS_REG_BANK_RANGE_CHECK_EN
    assign in_range_s = (address[ADDR_W-1:IDX_W+2] == {(ADDR_W-IDX_W-2){1'b0}});
`else
    assign in_range_s = 1'b1;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a simultaneous write and read start resolves to the write
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (wr_start_s) begin
                    state_nxt_s = WRITE;
                end else if (rd_start_s) begin
                    state_nxt_s = READ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WRITE:   state_nxt_s = HOLD;
            READ:    state_nxt_s = HOLD;
            HOLD: begin
                if (ws_sync_s && rs_sync_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Register array, read data, write pulse/index and busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= RESET_VAL;
            end
            data_out_r <= {DATA_W{1'b0}};
            wr_stb_r   <= 1'b0;
            wr_idx_r   <= {IDX_W{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            wr_stb_r <= 1'b0;
            busy_r   <= (state_nxt_s != IDLE);
            if (state_r == WRITE && in_range_s) begin
                for (int b = 0; b < DATA_W/8; b++) begin
                    if (be[b]) begin
                        regs_r[idx_s][8*b +: 8] <= data_in[8*b +: 8];
                    end
                end
                wr_stb_r <= 1'b1;
                wr_idx_r <= idx_s;
            end
            if (state_r == READ) begin
                data_out_r <= in_range_s ? regs_r[idx_s] : {DATA_W{1'b0}};
            end
        end
    end

`ifdef BUS_REG_BANK_RANGE_CHECK_EN
    logic range_err_r;

    // Sticky flag for any access outside the implemented window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            range_err_r <= 1'b0;
        end else if ((state_r == WRITE || state_r == READ) && !in_range_s) begin
            range_err_r <= 1'b1;
        end
    end

    assign range_err = range_err_r;
`else
    assign range_err = 1'b0;
`endif

    assign data_out = data_out_r;
    assign ctrl_q   = regs_r[0];
    assign wr_stb   = wr_stb_r;
    assign wr_idx   = wr_idx_r;
    assign busy     = busy_r;

endmodule
